// File: rtl/mul_acc.sv
// mul_acc: saturating signed accumulator for 10-bit Booth products.
// Products arrive over a valid/ready handshake and are summed into groups.
// A group closes on in_last or after MAX_TERMS products. The closed group's
// sum, term count and overflow flag are then offered on an output handshake.
module mul_acc #(
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_cnt,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [7:0]       MAX_CNT = 8'(MAX_TERMS);
    localparam logic [ACC_W-1:0] SAT_HI  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_LO  = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [7:0]         cnt;
    logic [7:0]         cnt_next;
    logic               ovf;
    logic               ovf_next;
    logic [ACC_W-1:0]   out_sum_next;
    logic [7:0]         out_cnt_next;
    logic               out_ovf_next;

    logic               accept;
    logic               close;
    logic [ACC_W:0]     sum_ext;
    logic               pos_sat;
    logic               neg_sat;
    logic [ACC_W-1:0]   sat_sum;
    logic [7:0]         cnt_inc;

    // Handshake flags decode straight from the state flop, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_OUT);

    // Widened add plus clamp: one guard bit is enough because a 10-bit
    // product added to an ACC_W-bit value (ACC_W >= 11) cannot overflow
    // ACC_W+1 bits; disagreeing top two bits mean the sum left the range.
    always_comb begin
        sum_ext = {acc[ACC_W-1], acc} + {{(ACC_W-9){in_prod[9]}}, in_prod};
        pos_sat = !sum_ext[ACC_W] &&  sum_ext[ACC_W-1];
        neg_sat =  sum_ext[ACC_W] && !sum_ext[ACC_W-1];
        if (pos_sat) begin
            sat_sum = SAT_HI;
        end else if (neg_sat) begin
            sat_sum = SAT_LO;
        end else begin
            sat_sum = sum_ext[ACC_W-1:0];
        end
        cnt_inc = cnt + 8'd1;
        accept  = in_valid && (state == ST_ACC);
        close   = accept && (in_last || (cnt_inc == MAX_CNT));
    end

    // Next-state and datapath update; clr overrides both accept and handoff
    // but leaves the last published result untouched.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        ovf_next     = ovf;
        out_sum_next = out_sum;
        out_cnt_next = out_cnt;
        out_ovf_next = out_ovf;
        if (clr) begin
            state_next = ST_ACC;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (close) begin
                        out_sum_next = sat_sum;
                        out_cnt_next = cnt_inc;
                        out_ovf_next = ovf || pos_sat || neg_sat;
                        acc_next     = '0;
                        cnt_next     = '0;
                        ovf_next     = 1'b0;
                        state_next   = ST_OUT;
                    end else if (accept) begin
                        acc_next = sat_sum;
                        cnt_next = cnt_inc;
                        ovf_next = ovf || pos_sat || neg_sat;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_next = ST_ACC;
                    end
                end
                default: begin
                    state_next = ST_ACC;
                end
            endcase
        end
    end

    // State, accumulator and result registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            ovf     <= ovf_next;
            out_sum <= out_sum_next;
            out_cnt <= out_cnt_next;
            out_ovf <= out_ovf_next;
        end
    end

endmodule

// File: tb/tb_mul_acc.sv
// tb_mul_acc: directed and randomized checks of mul_acc against an
// integer-arithmetic reference model of the grouping/saturation rules.
module tb_mul_acc;

    localparam int ACC_W     = 12;
    localparam int MAX_TERMS = 8;
    localparam int LIM_HI    = (1 << (ACC_W-1)) - 1;
    localparam int LIM_LO    = -(1 << (ACC_W-1));

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_cnt;
    logic             out_ovf;

    int n_cmp;
    int n_bad;

    // Reference model state (plain integers)
    int m_acc;
    int m_cnt;
    bit m_ovf;
    bit m_out;
    int m_sum;
    int m_ocnt;
    bit m_oovf;

    mul_acc #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] to_bits(input int v);
        logic [31:0] w;
        w = 32'(v);
        return w[ACC_W-1:0];
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_ovf = 0; m_out = 0;
        m_sum = 0; m_ocnt = 0; m_oovf = 0;
    endtask

    // One clock edge of the reference model, from the inputs held across it
    task automatic model_edge(input bit c, input bit v, input int p, input bit l, input bit r);
        int s;
        if (c) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_out = 0;
        end else if (!m_out) begin
            if (v) begin
                s = m_acc + p;
                if (s > LIM_HI) begin s = LIM_HI; m_ovf = 1; end
                if (s < LIM_LO) begin s = LIM_LO; m_ovf = 1; end
                m_acc = s;
                m_cnt = m_cnt + 1;
                if (l || m_cnt == MAX_TERMS) begin
                    m_sum = m_acc; m_ocnt = m_cnt; m_oovf = m_ovf; m_out = 1;
                    m_acc = 0; m_cnt = 0; m_ovf = 0;
                end
            end
        end else if (r) begin
            m_out = 0;
        end
    endtask

    // Drive one cycle of inputs from a negedge, clock it, return at next negedge
    task automatic drive_cycle(input bit c, input bit v, input int p, input bit l, input bit r);
        logic [31:0] pw;
        pw        = 32'(p);
        clr       = c;
        in_valid  = v;
        in_prod   = pw[9:0];
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        model_edge(c, v, p, l, r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 0; in_valid = 0; in_prod = '0; in_last = 0; out_ready = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL reset_out_sum got %0d want 0", $signed(out_sum)); end
        n_cmp++; if (out_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_group();
        drive_cycle(0, 1, 5, 0, 0);
        drive_cycle(0, 1, -3, 0, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        drive_cycle(0, 1, 7, 1, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", out_valid); end
        n_cmp++; if (out_sum !== to_bits(9)) begin n_bad++; $display("FAIL basic_sum got %0d want 9", $signed(out_sum)); end
        n_cmp++; if (out_cnt !== 8'd3) begin n_bad++; $display("FAIL basic_cnt got %0d want 3", out_cnt); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready got %b want 0", in_ready); end
        drive_cycle(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_handoff got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        n_cmp++; if (out_sum !== to_bits(9)) begin n_bad++; $display("FAIL basic_sum_kept got %0d want 9", $signed(out_sum)); end
    endtask

    task automatic test_neg_boundary();
        // Exactly the most negative value: no saturation
        for (int i = 0; i < 4; i++) drive_cycle(0, 1, -512, (i == 3), 0);
        n_cmp++; if (out_sum !== to_bits(LIM_LO) || out_ovf !== 1'b0 || out_cnt !== 8'd4) begin
            n_bad++; $display("FAIL neg_exact got sum=%0d ovf=%b cnt=%0d want -2048 0 4", $signed(out_sum), out_ovf, out_cnt); end
        drive_cycle(0, 0, 0, 0, 1);
        // Eight terms without in_last auto-close and saturate low
        for (int i = 0; i < 8; i++) drive_cycle(0, 1, -512, 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_cnt !== 8'd8) begin
            n_bad++; $display("FAIL auto_close got v=%b cnt=%0d want 1 8", out_valid, out_cnt); end
        n_cmp++; if (out_sum !== to_bits(LIM_LO) || out_ovf !== 1'b1) begin
            n_bad++; $display("FAIL neg_sat got sum=%0d ovf=%b want -2048 1", $signed(out_sum), out_ovf); end
        // Ninth product waits while OUT is held
        drive_cycle(0, 1, 33, 1, 0);
        n_cmp++; if (in_ready !== 1'b0 || out_cnt !== 8'd8) begin
            n_bad++; $display("FAIL ninth_wait got r=%b cnt=%0d want 0 8", in_ready, out_cnt); end
        drive_cycle(0, 1, 33, 1, 1);
        drive_cycle(0, 1, 33, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== to_bits(33) || out_cnt !== 8'd1) begin
            n_bad++; $display("FAIL ninth_group got v=%b sum=%0d cnt=%0d want 1 33 1", out_valid, $signed(out_sum), out_cnt); end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_pos_saturate();
        for (int i = 0; i < 8; i++) drive_cycle(0, 1, 511, 0, 0);
        n_cmp++; if (out_sum !== to_bits(LIM_HI) || out_ovf !== 1'b1 || out_cnt !== 8'd8) begin
            n_bad++; $display("FAIL pos_sat got sum=%0d ovf=%b cnt=%0d want 2047 1 8", $signed(out_sum), out_ovf, out_cnt); end
        drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(0, 1, 1, 0, 0);
        drive_cycle(0, 1, -1, 1, 0);
        n_cmp++; if (out_sum !== to_bits(0) || out_ovf !== 1'b0 || out_cnt !== 8'd2) begin
            n_bad++; $display("FAIL ovf_cleared got sum=%0d ovf=%b cnt=%0d want 0 0 2", $signed(out_sum), out_ovf, out_cnt); end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        drive_cycle(0, 1, 20, 0, 0);
        drive_cycle(0, 1, 30, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 100, 1, 0);
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== to_bits(50) || out_cnt !== 8'd2) begin
                n_bad++; $display("FAIL bp_hold got v=%b r=%b sum=%0d cnt=%0d want 1 0 50 2", out_valid, in_ready, $signed(out_sum), out_cnt); end
        end
        drive_cycle(0, 1, 100, 1, 1);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_handoff got v=%b r=%b want 0 1", out_valid, in_ready); end
        drive_cycle(0, 1, 100, 1, 0);
        n_cmp++; if (out_sum !== to_bits(100) || out_cnt !== 8'd1) begin
            n_bad++; $display("FAIL bp_held_product got sum=%0d cnt=%0d want 100 1", $signed(out_sum), out_cnt); end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 10 + i, 0, 0);
        drive_cycle(1, 1, 50, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || out_sum !== to_bits(100)) begin
            n_bad++; $display("FAIL clr_no_accept got v=%b sum=%0d want 0 100", out_valid, $signed(out_sum)); end
        drive_cycle(0, 1, 4, 1, 0);
        n_cmp++; if (out_sum !== to_bits(4) || out_cnt !== 8'd1) begin
            n_bad++; $display("FAIL clr_result got sum=%0d cnt=%0d want 4 1", $signed(out_sum), out_cnt); end
        // clr while a result is pending discards it but keeps the registers
        drive_cycle(1, 0, 0, 0, 0);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== to_bits(4)) begin
            n_bad++; $display("FAIL clr_in_out got v=%b r=%b sum=%0d want 0 1 4", out_valid, in_ready, $signed(out_sum)); end
    endtask

    task automatic test_async_reset();
        drive_cycle(0, 1, -77, 0, 0);
        drive_cycle(0, 1, 12, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== to_bits(-65)) begin
            n_bad++; $display("FAIL ar_pre got v=%b sum=%0d want 1 -65", out_valid, $signed(out_sum)); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL ar_immediate got v=%b sum=%0d r=%b want 0 0 1", out_valid, $signed(out_sum), in_ready); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(0, 1, 200, 0, 0);
        drive_cycle(0, 1, -50, 1, 0);
        n_cmp++; if (out_sum !== to_bits(150) || out_cnt !== 8'd2 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL ar_fresh got sum=%0d cnt=%0d v=%b want 150 2 1", $signed(out_sum), out_cnt, out_valid); end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        int groups;
        groups = 0;
        for (int i = 0; i < 27; i++) begin
            drive_cycle(0, 1, 3, 0, 1);
            if (out_valid === 1'b1) groups++;
            n_cmp++; if (out_valid !== m_out) begin
                n_bad++; $display("FAIL b2b_valid cyc=%0d got %b want %b", i, out_valid, m_out); end
        end
        n_cmp++; if (groups !== 3) begin n_bad++; $display("FAIL b2b_groups got %0d want 3", groups); end
        n_cmp++; if (out_sum !== to_bits(24) || out_cnt !== 8'd8) begin
            n_bad++; $display("FAIL b2b_sum got sum=%0d cnt=%0d want 24 8", $signed(out_sum), out_cnt); end
    endtask

    task automatic test_random();
        bit c, v, l, r;
        int p;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = int'($urandom_range(0, 1023)) - 512;
            if ($urandom_range(0, 3) == 0) p = ($urandom_range(0, 1) == 0) ? 511 : -512;
            l = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 1) == 0);
            drive_cycle(c, v, p, l, r);
            n_cmp++; if (in_ready !== !m_out || out_valid !== m_out) begin
                n_bad++; $display("FAIL rnd_hs cyc=%0d got r=%b v=%b want r=%b v=%b", i, in_ready, out_valid, !m_out, m_out); end
            n_cmp++; if (out_sum !== to_bits(m_sum)) begin
                n_bad++; $display("FAIL rnd_sum cyc=%0d got %0d want %0d", i, $signed(out_sum), m_sum); end
            n_cmp++; if (out_cnt !== 8'(m_ocnt) || out_ovf !== m_oovf) begin
                n_bad++; $display("FAIL rnd_cnt_ovf cyc=%0d got cnt=%0d ovf=%b want cnt=%0d ovf=%b", i, out_cnt, out_ovf, m_ocnt, m_oovf); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic_group();
        test_neg_boundary();
        test_pos_saturate();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
